// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the control unit: opcodes, FSM states, instruction classes
// and bit positions inside the one-hot out_sel / in_sel buses.
package cpu_ctrl_pkg;

  localparam int OUT_W = 24;
  localparam int IN_W  = 26;

  localparam int OUT_HI     = 16;
  localparam int OUT_LO     = 17;
  localparam int OUT_PC     = 20;
  localparam int OUT_MDR    = 21;
  localparam int OUT_INPORT = 22;
  localparam int OUT_C      = 23;

  localparam int IN_LO      = 17;
  localparam int IN_PC      = 20;
  localparam int IN_MDR     = 21;
  localparam int IN_MAR     = 22;
  localparam int IN_OUTPORT = 24;
  localparam int IN_IR      = 25;

  localparam logic [4:0] OP_IN   = 5'b01010;
  localparam logic [4:0] OP_OUT  = 5'b01011;
  localparam logic [4:0] OP_MFHI = 5'b01100;
  localparam logic [4:0] OP_MFLO = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_LDI  = 5'b10100;
  localparam logic [4:0] OP_LD   = 5'b10101;
  localparam logic [4:0] OP_ST   = 5'b10110;
  localparam logic [4:0] OP_RSV  = 5'b10111;
  localparam logic [4:0] OP_JR   = 5'b11100;
  localparam logic [4:0] OP_JAL  = 5'b11101;
  localparam logic [4:0] OP_NOP  = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_EX1, ST_EX2, ST_EX3, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_MULDIV, C_MFHI, C_MFLO, C_IN, C_OUT, C_LOAD, C_STORE,
    C_BR, C_JR, C_JAL, C_NOP, C_HALT, C_RSV
  } iclass_t;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit bus: IR/flag/start into the FSM, register selects and strobes out.
interface cpu_control_unit_if;
  import cpu_ctrl_pkg::*;

  logic              start;
  logic [31:0]       ir;
  logic              con_ff;
  logic [OUT_W-1:0]  out_sel;
  logic [IN_W-1:0]   in_sel;
  logic              mdr_read;
  logic              alu_en;
  logic              inc_pc;
  logic              ba_out;
  logic              run;
  logic              illegal;

  // master: the control unit; slave: the datapath it steers
  modport master (
    input  start, ir, con_ff,
    output out_sel, in_sel, mdr_read, alu_en, inc_pc, ba_out, run, illegal
  );

  modport slave (
    output start, ir, con_ff,
    input  out_sel, in_sel, mdr_read, alu_en, inc_pc, ba_out, run, illegal
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational IR decode: opcode -> instruction class, rd/ra as one-hot register masks.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls,
  output logic [15:0] rd_oh,
  output logic [15:0] ra_oh
);

  logic [4:0] op;
  logic       unused_bits;

  assign op          = ir[31:27];
  assign rd_oh       = reg_onehot(ir[26:23]);
  assign ra_oh       = reg_onehot(ir[22:19]);
  assign unused_bits = ^ir[18:0];

  always_comb begin
    cls = C_NOP;
    casez (op)
      5'b00???, 5'b0100?, 5'b100??: cls = C_ALU;
      OP_MUL, OP_DIV:               cls = C_MULDIV;
      OP_MFHI:                      cls = C_MFHI;
      OP_MFLO:                      cls = C_MFLO;
      OP_IN:                        cls = C_IN;
      OP_OUT:                       cls = C_OUT;
      OP_LDI, OP_LD:                cls = C_LOAD;
      OP_ST:                        cls = C_STORE;
      OP_RSV:                       cls = C_RSV;
      5'b110??:                     cls = C_BR;
      OP_JR:                        cls = C_JR;
      OP_JAL:                       cls = C_JAL;
      OP_NOP:                       cls = C_NOP;
      OP_HALT:                      cls = C_HALT;
      default:                      cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: one control step per clock, outputs decoded
// from the state register plus the held IR word (con_ff qualifies branches in EX1).
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter bit START_ON_RESET = 1'b0,
  parameter int LINK_REG       = 15
) (
  input  logic               clk,
  input  logic               clr,
  cpu_control_unit_if.master bus
);

  localparam logic [15:0] LINK_OH = reg_onehot(4'(LINK_REG));

  state_t            state, state_nxt;
  iclass_t           cls;
  logic [15:0]       rd_oh, ra_oh;
  logic [OUT_W-1:0]  out_sel_d;
  logic [IN_W-1:0]   in_sel_d;
  logic              mdr_read_d, alu_en_d, inc_pc_d, ba_out_d, illegal_d;

  instr_decode u_decode (
    .ir    (bus.ir),
    .cls   (cls),
    .rd_oh (rd_oh),
    .ra_oh (ra_oh)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    out_sel_d  = '0;
    in_sel_d   = '0;
    mdr_read_d = 1'b0;
    alu_en_d   = 1'b0;
    inc_pc_d   = 1'b0;
    ba_out_d   = 1'b0;
    illegal_d  = 1'b0;
    case (state)
      ST_IDLE: if (bus.start || START_ON_RESET) state_nxt = ST_FETCH0;
      ST_FETCH0: begin
        out_sel_d[OUT_PC] = 1'b1;
        in_sel_d[IN_MAR]  = 1'b1;
        inc_pc_d          = 1'b1;
        state_nxt         = ST_FETCH1;
      end
      ST_FETCH1: begin
        mdr_read_d       = 1'b1;
        in_sel_d[IN_MDR] = 1'b1;
        state_nxt        = ST_FETCH2;
      end
      ST_FETCH2: begin
        out_sel_d[OUT_MDR] = 1'b1;
        in_sel_d[IN_IR]    = 1'b1;
        state_nxt          = ST_EX1;
      end
      ST_EX1: begin
        state_nxt = ST_FETCH0;
        case (cls)
          C_ALU, C_MULDIV: begin
            alu_en_d  = 1'b1;
            state_nxt = ST_EX2;
          end
          C_MFHI: begin
            out_sel_d[OUT_HI] = 1'b1;
            in_sel_d[15:0]    = rd_oh;
          end
          C_MFLO: begin
            out_sel_d[OUT_LO] = 1'b1;
            in_sel_d[15:0]    = rd_oh;
          end
          C_IN: begin
            out_sel_d[OUT_INPORT] = 1'b1;
            in_sel_d[15:0]        = rd_oh;
          end
          C_OUT: begin
            out_sel_d[15:0]      = ra_oh;
            in_sel_d[IN_OUTPORT] = 1'b1;
          end
          C_LOAD, C_STORE: begin
            in_sel_d[IN_MAR] = 1'b1;
            ba_out_d         = 1'b1;
            state_nxt        = ST_EX2;
          end
          // datapath routes R[ra] onto the PC input when the condition holds
          C_BR: in_sel_d[IN_PC] = bus.con_ff;
          C_JR: begin
            out_sel_d[15:0] = ra_oh;
            in_sel_d[IN_PC] = 1'b1;
          end
          C_JAL: begin
            out_sel_d[OUT_PC] = 1'b1;
            in_sel_d[15:0]    = LINK_OH;
            state_nxt         = ST_EX2;
          end
          C_HALT: state_nxt = ST_HALT;
          C_RSV:  illegal_d = 1'b1;
          default: ;
        endcase
      end
      ST_EX2: begin
        state_nxt = ST_FETCH0;
        case (cls)
          C_ALU: begin
            out_sel_d[OUT_C] = 1'b1;
            in_sel_d[15:0]   = rd_oh;
          end
          C_MULDIV: begin
            out_sel_d[OUT_C] = 1'b1;
            in_sel_d[IN_LO]  = 1'b1;
          end
          C_LOAD: begin
            alu_en_d  = 1'b1;
            state_nxt = ST_EX3;
          end
          // link was written in EX1, so ra==LINK_REG jumps to the new link value
          C_JAL: begin
            out_sel_d[15:0] = ra_oh;
            in_sel_d[IN_PC] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EX3: begin
        out_sel_d[OUT_C] = 1'b1;
        in_sel_d[15:0]   = rd_oh;
        state_nxt        = ST_FETCH0;
      end
      ST_HALT: state_nxt = ST_HALT;
    endcase
  end

  assign bus.out_sel  = out_sel_d;
  assign bus.in_sel   = in_sel_d;
  assign bus.mdr_read = mdr_read_d;
  assign bus.alu_en   = alu_en_d;
  assign bus.inc_pc   = inc_pc_d;
  assign bus.ba_out   = ba_out_d;
  assign bus.illegal  = illegal_d;
  assign bus.run      = (state != ST_IDLE) && (state != ST_HALT);

endmodule
